// File: rtl/spi_reg_master.sv
// SPI mode-0 master for the register slave: one 16-bit frame per request,
// command byte {rw, width, pad, addr} followed by a write or read data byte.
// The slave status byte clocked in during the command byte is kept as well.
module spi_reg_master #(
  parameter int ADDR_W   = 3,
  parameter int REG_W    = 8,
  parameter int HALF_DIV = 4,
  parameter int BYTE_GAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              start,
  input  logic              rw,
  input  logic [1:0]        width,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic [REG_W-1:0]  rdata,
  output logic [REG_W-1:0]  status,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n
);

  localparam int FRAME_W = 2 * REG_W;
  localparam int CNT_W   = $clog2(HALF_DIV + BYTE_GAP);
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(HALF_DIV + BYTE_GAP - 1);
  localparam logic [BIT_W-1:0] BYTE_LAST = BIT_W'(REG_W - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RECOVER} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     hcnt, hcnt_n;
  logic [BIT_W-1:0]     bcnt, bcnt_n;
  logic [FRAME_W-1:0]   tx_sr, tx_n;
  logic [FRAME_W-1:0]   rx_sr, rx_n;
  logic                 rw_q, rw_n;
  logic                 busy_n, done_n, sclk_n, cs_n_n;
  logic [REG_W-1:0]     rdata_n, status_n;
  logic [CNT_W-1:0]     low_last;

  // Command byte: rw in the MSB, width below it, address in the LSBs, zeros between.
  function automatic logic [REG_W-1:0] make_cmd(input logic r, input logic [1:0] w,
                                                input logic [ADDR_W-1:0] a);
    logic [REG_W-1:0] c;
    c = '0;
    c[REG_W-1] = r;
    c[REG_W-2 -: 2] = w;
    c[ADDR_W-1:0] = a;
    return c;
  endfunction

  // MOSI is always the top of the TX register; zeros shift in behind the frame.
  assign spi_mosi = tx_sr[FRAME_W-1];

  // The low phase after the last command bit is stretched by the byte gap.
  assign low_last = (bcnt == BYTE_LAST) ? GAP_LAST : H_LAST;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_n  = state;
    hcnt_n   = hcnt;
    bcnt_n   = bcnt;
    tx_n     = tx_sr;
    rx_n     = rx_sr;
    rw_n     = rw_q;
    busy_n   = busy;
    done_n   = done;
    sclk_n   = spi_clk;
    cs_n_n   = spi_cs_n;
    rdata_n  = rdata;
    status_n = status;
    case (state)
      IDLE: begin
        done_n = 1'b0;
        busy_n = 1'b0;
        if (start && !busy) begin
          state_n = SETUP;
          hcnt_n  = '0;
          busy_n  = 1'b1;
          cs_n_n  = 1'b0;
          rw_n    = rw;
          tx_n    = {make_cmd(rw, width, addr), (rw ? wdata : {REG_W{1'b0}})};
        end
      end
      SETUP: begin
        if (hcnt == H_LAST) begin
          state_n = SHIFT;
          hcnt_n  = '0;
          bcnt_n  = '0;
          sclk_n  = 1'b1;
          rx_n    = {rx_sr[FRAME_W-2:0], spi_miso};
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      SHIFT: begin
        if (spi_clk) begin
          if (hcnt == H_LAST) begin
            hcnt_n = '0;
            sclk_n = 1'b0;
            tx_n   = {tx_sr[FRAME_W-2:0], 1'b0};
            if (bcnt == BIT_LAST) state_n = HOLD;
          end else begin
            hcnt_n = hcnt + 1'b1;
          end
        end else begin
          if (hcnt == low_last) begin
            hcnt_n = '0;
            sclk_n = 1'b1;
            bcnt_n = bcnt + 1'b1;
            rx_n   = {rx_sr[FRAME_W-2:0], spi_miso};
          end else begin
            hcnt_n = hcnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (hcnt == H_LAST) begin
          state_n = RECOVER;
          hcnt_n  = '0;
          cs_n_n  = 1'b1;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      RECOVER: begin
        if (hcnt == H_LAST) begin
          state_n  = IDLE;
          hcnt_n   = '0;
          done_n   = 1'b1;
          status_n = rx_sr[FRAME_W-1:REG_W];
          if (!rw_q) rdata_n = rx_sr[REG_W-1:0];
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control and output registers; reset abandons any frame, ena freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hcnt     <= '0;
      bcnt     <= '0;
      tx_sr    <= '0;
      rw_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_clk  <= 1'b0;
      spi_cs_n <= 1'b1;
      rdata    <= '0;
      status   <= '0;
    end else if (ena) begin
      state    <= state_n;
      hcnt     <= hcnt_n;
      bcnt     <= bcnt_n;
      tx_sr    <= tx_n;
      rw_q     <= rw_n;
      busy     <= busy_n;
      done     <= done_n;
      spi_clk  <= sclk_n;
      spi_cs_n <= cs_n_n;
      rdata    <= rdata_n;
      status   <= status_n;
    end
  end

  // Receive shift register; its contents only matter once a full frame is in.
  always_ff @(posedge clk) begin
    if (ena) rx_sr <= rx_n;
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: two instances (no byte gap / 6-cycle byte gap),
// a behavioural SPI slave + bus monitor per instance, directed table,
// randomized transactions, stall/ignored-start and mid-frame reset sequences.
module tb_spi_reg_master;

  localparam int H  = 4;
  localparam int R  = 8;
  localparam int G1 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2], ena[2], start[2], rw[2];
  logic [1:0] width[2];
  logic [2:0] addr[2];
  logic [7:0] wdata[2];
  logic       busy[2], done[2];
  logic [7:0] rdata[2], status[2];
  logic       spi_clk[2], spi_mosi[2], spi_miso[2], spi_cs_n[2];

  spi_reg_master #(.ADDR_W(3), .REG_W(R), .HALF_DIV(H), .BYTE_GAP(0)) dut0 (
    .clk(clk), .rst(rst[0]), .ena(ena[0]), .start(start[0]), .rw(rw[0]),
    .width(width[0]), .addr(addr[0]), .wdata(wdata[0]), .busy(busy[0]),
    .done(done[0]), .rdata(rdata[0]), .status(status[0]), .spi_clk(spi_clk[0]),
    .spi_mosi(spi_mosi[0]), .spi_miso(spi_miso[0]), .spi_cs_n(spi_cs_n[0]));

  spi_reg_master #(.ADDR_W(3), .REG_W(R), .HALF_DIV(H), .BYTE_GAP(G1)) dut1 (
    .clk(clk), .rst(rst[1]), .ena(ena[1]), .start(start[1]), .rw(rw[1]),
    .width(width[1]), .addr(addr[1]), .wdata(wdata[1]), .busy(busy[1]),
    .done(done[1]), .rdata(rdata[1]), .status(status[1]), .spi_clk(spi_clk[1]),
    .spi_mosi(spi_mosi[1]), .spi_miso(spi_miso[1]), .spi_cs_n(spi_cs_n[1]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and bus monitor state
  logic        prev_cs[2]   = '{1'b1, 1'b1};
  logic        prev_sclk[2] = '{1'b0, 1'b0};
  logic        prev_done[2] = '{1'b0, 1'b0};
  logic [15:0] slv_sr[2], slv_load[2], mosi_cap[2];
  int rises[2], falls[2], frames[2], dcnt[2];
  int cs_fall_cyc[2], cs_rise_cyc[2], first_rise_cyc[2], fall8_cyc[2], gap_meas[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (prev_cs[i] && !spi_cs_n[i]) begin
        frames[i]++;
        cs_fall_cyc[i] = cyc;
        rises[i] = 0;
        falls[i] = 0;
        dcnt[i] = 0;
        gap_meas[i] = -1;
        mosi_cap[i] = '0;
        slv_sr[i] = slv_load[i];
        spi_miso[i] = slv_load[i][15];
      end
      if (!prev_cs[i] && spi_cs_n[i]) cs_rise_cyc[i] = cyc;
      if (!prev_sclk[i] && spi_clk[i]) begin
        if (rises[i] == 0) first_rise_cyc[i] = cyc;
        if (rises[i] == R) gap_meas[i] = cyc - fall8_cyc[i];
        mosi_cap[i] = {mosi_cap[i][14:0], spi_mosi[i]};
        rises[i]++;
      end
      if (prev_sclk[i] && !spi_clk[i] && !spi_cs_n[i]) begin
        falls[i]++;
        if (falls[i] == R) fall8_cyc[i] = cyc;
        slv_sr[i] = {slv_sr[i][14:0], 1'b0};
        spi_miso[i] = slv_sr[i][15];
      end
      if (!prev_done[i] && done[i]) dcnt[i]++;
      prev_cs[i]   = spi_cs_n[i];
      prev_sclk[i] = spi_clk[i];
      prev_done[i] = done[i];
    end
  end

  int total = 0;
  int bad   = 0;
  int exp_rd[2];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: frame = command byte then data byte, computed arithmetically.
  function automatic int model_frame(input int r, input int w, input int a, input int wd);
    return (r * 128 + w * 32 + a) * 256 + (r != 0 ? wd : 0);
  endfunction

  // Reference: cycle of done relative to acceptance cycle t0.
  function automatic int model_done(input int t0, input int g, input int stall);
    return t0 + 1 + H + 2 * H * (2 * R - 1) + g + 3 * H + stall;
  endfunction

  task automatic do_txn(input int k, input logic r, input logic [1:0] w, input logic [2:0] a,
                        input logic [7:0] wd, input logic [15:0] sl, input int ex_mosi,
                        input int ex_st, input int ex_rd, input int stall_at, input int stall_len);
    int t0, dc, fr0, g, ed;
    bit seen;
    g = (k == 0) ? 0 : G1;
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      if (!busy[k]) seen = 1;
      else tick();
    end
    chk("idle_wait", int'(seen), 1);
    slv_load[k] = sl;
    rw[k] = r; width[k] = w; addr[k] = a; wdata[k] = wd;
    start[k] = 1'b1;
    fr0 = frames[k];
    t0 = cyc;
    tick();
    start[k] = 1'b0;
    rw[k] = ~r; width[k] = ~w; addr[k] = ~a; wdata[k] = ~wd;
    chk("busy_after_accept", int'(busy[k]), 1);
    seen = 0;
    dc = 0;
    for (int c = 0; c < 600 && !seen; c++) begin
      if (done[k]) begin
        seen = 1;
        dc = cyc;
      end else begin
        if (stall_len > 0 && cyc == t0 + stall_at) ena[k] = 1'b0;
        if (stall_len > 0 && cyc == t0 + stall_at + stall_len) ena[k] = 1'b1;
        if (stall_len > 0 && cyc == t0 + 20) begin
          start[k] = 1'b1; rw[k] = 1'b1; addr[k] = 3'd1; wdata[k] = 8'h11;
        end
        if (stall_len > 0 && cyc == t0 + 22) start[k] = 1'b0;
        tick();
      end
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      ena[k] = 1'b1;
      start[k] = 1'b0;
      return;
    end
    ed = model_done(t0, g, stall_len);
    chk("done_cycle", dc - t0, ed - t0);
    chk("busy_at_done", int'(busy[k]), 1);
    tick();
    chk("busy_after_done", int'(busy[k]), 0);
    chk("done_one_cycle", int'(done[k]), 0);
    chk("done_pulses", dcnt[k], 1);
    chk("frames", frames[k] - fr0, 1);
    chk("rise_count", rises[k], 2 * R);
    chk("mosi_frame", int'(mosi_cap[k]), ex_mosi);
    chk("status", int'(status[k]), ex_st);
    chk("rdata", int'(rdata[k]), ex_rd);
    chk("cs_fall", cs_fall_cyc[k] - t0, 1);
    chk("first_rise", first_rise_cyc[k] - t0, 1 + H);
    chk("cs_rise", cs_rise_cyc[k] - t0, ed - H - t0);
    chk("byte_gap", gap_meas[k], H + g);
    chk("idle_lines", int'({spi_cs_n[k], spi_clk[k], spi_mosi[k]}), 3'b100);
    exp_rd[k] = ex_rd;
  endtask

  typedef struct {
    int          inst;
    logic        rw;
    logic [1:0]  width;
    logic [2:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] slv;
    int          exp_mosi;
    int          exp_st;
    int          exp_rd;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int seen;
    logic        r;
    logic [1:0]  w;
    logic [2:0]  a;
    logic [7:0]  wd;
    logic [15:0] sl;
    int          k;

    tbl[0] = '{0, 1'b1, 2'd3, 3'd5, 8'hA5, 16'hC377, 32'hE5A5, 32'hC3, 32'h00};
    tbl[1] = '{0, 1'b0, 2'd0, 3'd2, 8'hFF, 16'h813C, 32'h0200, 32'h81, 32'h3C};
    tbl[2] = '{0, 1'b1, 2'd1, 3'd7, 8'h5E, 16'h7711, 32'hA75E, 32'h77, 32'h3C};
    tbl[3] = '{0, 1'b0, 2'd2, 3'd0, 8'h00, 16'hFF00, 32'h4000, 32'hFF, 32'h00};
    tbl[4] = '{1, 1'b0, 2'd0, 3'd2, 8'h00, 16'h813C, 32'h0200, 32'h81, 32'h3C};
    tbl[5] = '{1, 1'b1, 2'd3, 3'd5, 8'hA5, 16'h0102, 32'hE5A5, 32'h01, 32'h3C};
    tbl[6] = '{0, 1'b0, 2'd3, 3'd6, 8'h12, 16'h0155, 32'h6600, 32'h01, 32'h55};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; ena[i] = 1'b1; start[i] = 1'b0; rw[i] = 1'b0;
      width[i] = '0; addr[i] = '0; wdata[i] = '0; slv_load[i] = '0;
      exp_rd[i] = 0;
    end
    repeat (3) tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (20) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs_n", int'(spi_cs_n[i]), 1);
      chk("rst_sclk", int'(spi_clk[i]), 0);
      chk("rst_mosi", int'(spi_mosi[i]), 0);
      chk("rst_busy", int'(busy[i]), 0);
      chk("rst_done", int'(done[i]), 0);
      chk("rst_rdata", int'(rdata[i]), 0);
      chk("rst_status", int'(status[i]), 0);
    end

    // Directed table; consecutive entries on one instance start on the busy-fall cycle.
    for (int i = 0; i < 7; i++)
      do_txn(tbl[i].inst, tbl[i].rw, tbl[i].width, tbl[i].addr, tbl[i].wdata, tbl[i].slv,
             tbl[i].exp_mosi, tbl[i].exp_st, tbl[i].exp_rd, 0, 0);

    // Mid-bit 7-cycle ena stall plus an ignored start pulse during the frame.
    do_txn(0, 1'b1, 2'd2, 3'd3, 8'h3C, 16'h9966, model_frame(1, 2, 3, 8'h3C), 32'h99,
           exp_rd[0], 40, 7);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 8; i++) begin
      k  = int'($urandom_range(0, 1));
      r  = 1'($urandom);
      w  = 2'($urandom);
      a  = 3'($urandom);
      wd = 8'($urandom);
      sl = 16'($urandom);
      do_txn(k, r, w, a, wd, sl, model_frame(int'(r), int'(w), int'(a), int'(wd)),
             int'(sl) / 256, (r ? exp_rd[k] : int'(sl) % 256), 0, 0);
    end

    // Reset while bit 10 is on the wire.
    seen = 0;
    for (int c = 0; c < 400 && busy[0]; c++) tick();
    slv_load[0] = 16'hDEAD;
    rw[0] = 1'b0; width[0] = 2'd1; addr[0] = 3'd4;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 0; c < 300 && seen == 0; c++) begin
      if (rises[0] == 11) seen = 1;
      else tick();
    end
    chk("reach_bit10", seen, 1);
    rst[0] = 1'b1;
    tick();
    chk("midrst_cs_n", int'(spi_cs_n[0]), 1);
    chk("midrst_busy", int'(busy[0]), 0);
    chk("midrst_sclk", int'(spi_clk[0]), 0);
    chk("midrst_rdata", int'(rdata[0]), 0);
    chk("midrst_status", int'(status[0]), 0);
    rst[0] = 1'b0;
    exp_rd[0] = 0;
    repeat (160) tick();
    chk("midrst_no_done", dcnt[0], 0);
    do_txn(0, 1'b1, 2'd1, 3'd4, 8'h3D, 16'h4242, model_frame(1, 1, 4, 8'h3D), 32'h42, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
